// File: rtl/i2c_arb_pkg.sv
// Shared types and widths for the i2c_arbiter slice: FSM state encoding and datapath widths.
package i2c_arb_pkg;

    localparam int unsigned ADDR_W = 7;
    localparam int unsigned DATA_W = 8;
    localparam int unsigned TMO_W  = 16;

    typedef enum logic [2:0] {
        StIdle   = 3'd0,
        StLoad   = 3'd1,
        StStrt   = 3'd2,
        StWaitLo = 3'd3,
        StWaitHi = 3'd4,
        StDone   = 3'd5
    } arb_state_e;

    // Width of a requester index; never zero so single-bit vectors stay legal.
    function automatic int unsigned idx_width(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/i2c_rr_pick.sv
// Combinational round-robin picker: first set request at or after the pointer, wrapping.
module i2c_rr_pick #(
    parameter int unsigned NREQ = 4,
    parameter int unsigned IDXW = 2
) (
    input  logic [NREQ-1:0] req,
    input  logic [IDXW-1:0] pointer,
    output logic [NREQ-1:0] winner,
    output logic [IDXW-1:0] index,
    output logic            valid
);

    int pos;

    always_comb begin
        winner = '0;
        index  = '0;
        valid  = 1'b0;
        pos    = 0;
        for (int unsigned i = 0; i < NREQ; i++) begin
            pos = int'(pointer) + int'(i);
            if (pos >= int'(NREQ)) begin
                pos = pos - int'(NREQ);
            end
            if (!valid && req[pos]) begin
                valid = 1'b1;
                index = IDXW'(pos);
            end
        end
        if (valid) begin
            winner[index] = 1'b1;
        end
    end

endmodule

// File: rtl/i2c_arbiter.sv
// Round-robin arbiter sharing one i2c_master among NREQ single-byte write requesters.
// Define ARB_TIMEOUT_EN to add a per-transaction watchdog that aborts and resets the master.
module i2c_arbiter
    import i2c_arb_pkg::*;
#(
    parameter int unsigned NREQ    = 4,
    parameter int unsigned TIMEOUT = 65535
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [NREQ-1:0]          req,
    input  logic [ADDR_W*NREQ-1:0]   req_addr,
    input  logic [DATA_W*NREQ-1:0]   req_data,
    output logic [NREQ-1:0]          grant,
    output logic [NREQ-1:0]          done,
    output logic [NREQ-1:0]          err,
    output logic                     busy,
    output logic [ADDR_W-1:0]        m_addr,
    output logic [DATA_W-1:0]        m_data,
    output logic                     m_start,
    input  logic                     m_ready,
    input  logic                     m_ack_fail,
    output logic                     m_reset
);

    localparam int unsigned IDXW = idx_width(NREQ);

    if (NREQ < 2 || NREQ > 8 || TIMEOUT == 0 || TIMEOUT > 65535) begin : g_param_check
        $error("i2c_arbiter: NREQ or TIMEOUT out of range");
    end

    arb_state_e        state_q, state_d;
    logic [IDXW-1:0]   ptr_q, ptr_d;
    logic [IDXW-1:0]   win_q, win_d;
    logic [NREQ-1:0]   grant_q, grant_d;
    logic [NREQ-1:0]   done_q, done_d;
    logic [NREQ-1:0]   err_q, err_d;
    logic              busy_q, busy_d;
    logic [ADDR_W-1:0] m_addr_q, m_addr_d;
    logic [DATA_W-1:0] m_data_q, m_data_d;
    logic              m_start_q, m_start_d;
    logic              m_reset_d;

    logic [NREQ-1:0]   pick_onehot;
    logic [IDXW-1:0]   pick_idx;
    logic              pick_valid;

    i2c_rr_pick #(
        .NREQ (NREQ),
        .IDXW (IDXW)
    ) u_pick (
        .req     (req),
        .pointer (ptr_q),
        .winner  (pick_onehot),
        .index   (pick_idx),
        .valid   (pick_valid)
    );

`ifdef ARB_TIMEOUT_EN
    localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT - 1);
    logic [TMO_W-1:0] tmo_q, tmo_d;
    logic             m_reset_q;
`endif

    always_comb begin
        state_d   = state_q;
        ptr_d     = ptr_q;
        win_d     = win_q;
        grant_d   = grant_q;
        done_d    = '0;
        err_d     = '0;
        m_addr_d  = m_addr_q;
        m_data_d  = m_data_q;
        m_start_d = 1'b1;
        m_reset_d = 1'b1;
`ifdef ARB_TIMEOUT_EN
        tmo_d     = tmo_q;
`endif

        unique case (state_q)
            StIdle: begin
                // Winner's slices are captured here so m_addr/m_data are valid during LOAD.
                if (pick_valid && m_ready) begin
                    state_d  = StLoad;
                    win_d    = pick_idx;
                    grant_d  = pick_onehot;
                    m_addr_d = req_addr[int'(pick_idx)*ADDR_W +: ADDR_W];
                    m_data_d = req_data[int'(pick_idx)*DATA_W +: DATA_W];
                end
            end
            StLoad: begin
                state_d   = StStrt;
                m_start_d = 1'b0;
            end
            StStrt: begin
                state_d = StWaitLo;
            end
            StWaitLo: begin
                if (!m_ready) begin
                    state_d = StWaitHi;
                end
            end
            StWaitHi: begin
                if (m_ready) begin
                    state_d       = StDone;
                    done_d[win_q] = 1'b1;
                    err_d[win_q]  = m_ack_fail;
                end
            end
            StDone: begin
                state_d = StIdle;
                grant_d = '0;
                ptr_d   = (win_q == IDXW'(NREQ - 1)) ? '0 : win_q + 1'b1;
            end
            default: begin
                state_d = StIdle;
                grant_d = '0;
            end
        endcase

`ifdef ARB_TIMEOUT_EN
        if (state_q == StLoad) begin
            tmo_d = '0;
        end else if (state_q == StWaitLo || state_q == StWaitHi) begin
            tmo_d = tmo_q + 1'b1;
            // A normal completion in the same cycle wins over the watchdog.
            if (tmo_q == TMO_LAST && state_d != StDone) begin
                state_d       = StDone;
                done_d        = '0;
                err_d         = '0;
                done_d[win_q] = 1'b1;
                err_d[win_q]  = 1'b1;
                m_reset_d     = 1'b0;
            end
        end
`endif

        busy_d = (state_d != StIdle);
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q   <= StIdle;
            ptr_q     <= '0;
            win_q     <= '0;
            grant_q   <= '0;
            done_q    <= '0;
            err_q     <= '0;
            busy_q    <= 1'b0;
            m_addr_q  <= '0;
            m_data_q  <= '0;
            m_start_q <= 1'b1;
        end else begin
            state_q   <= state_d;
            ptr_q     <= ptr_d;
            win_q     <= win_d;
            grant_q   <= grant_d;
            done_q    <= done_d;
            err_q     <= err_d;
            busy_q    <= busy_d;
            m_addr_q  <= m_addr_d;
            m_data_q  <= m_data_d;
            m_start_q <= m_start_d;
        end
    end

`ifdef ARB_TIMEOUT_EN
    always_ff @(posedge clk) begin
        if (!reset) begin
            tmo_q     <= '0;
            m_reset_q <= 1'b1;
        end else begin
            tmo_q     <= tmo_d;
            m_reset_q <= m_reset_d;
        end
    end

    assign m_reset = m_reset_q;
`else
    logic unused_m_reset_d;
    assign unused_m_reset_d = m_reset_d;
    assign m_reset          = 1'b1;
`endif

    assign grant   = grant_q;
    assign done    = done_q;
    assign err     = err_q;
    assign busy    = busy_q;
    assign m_addr  = m_addr_q;
    assign m_data  = m_data_q;
    assign m_start = m_start_q;

endmodule
